// File: rtl/uart_top_core_if.sv
// uart_top_core_if : parallel TX/RX handshake plus serial pins of the UART core.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

interface uart_top_core_if #(
  parameter int DATABITS = 8
);
  logic [DATABITS-1:0] tx_data;
  logic                tx_en;
  logic                tx_busy;
  logic [DATABITS-1:0] rx_data;
  logic                rx_valid;
  logic                rx_error;
  logic                rxd;
  logic                txd;

  modport master (
    output tx_data, tx_en, rxd,
    input  tx_busy, rx_data, rx_valid, rx_error, txd
  );

  modport slave (
    input  tx_data, tx_en, rxd,
    output tx_busy, rx_data, rx_valid, rx_error, txd
  );
endinterface

`default_nettype wire

// File: rtl/uart_top_core.sv
// ------------------------------------------------------------------------
// uart_top_core : full-duplex UART, compile-time frame format.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote on each RX bit sample.
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module uart_top_core #(
  parameter int    FREQUENCY = 50_000_000,
  parameter int    BAUDRATE  = 115200,
  parameter int    DATABITS  = 8,
  parameter string PARITY    = "N",
  parameter real   STOPBITS  = 1.0,
  parameter string CHECKSTOP = "ENABLE"
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_top_core_if.slave   bus
);

  localparam int c_bp          = FREQUENCY / BAUDRATE;
  localparam int c_half        = c_bp / 2;
  localparam int c_stop_halves = $rtoi(STOPBITS * 2.0 + 0.5);
  localparam int c_stop_clks   = (c_stop_halves * c_bp) / 2;
  localparam int c_cw          = $clog2(c_stop_clks + c_bp + 1);
  localparam int c_bw          = $clog2(DATABITS);
  localparam bit c_has_par     = (PARITY != "N");
  localparam bit c_chk_stop    = (CHECKSTOP == "ENABLE");

  localparam logic [c_cw-1:0] c_bit_last  = c_cw'(c_bp - 1);
  localparam logic [c_cw-1:0] c_half_last = c_cw'(c_half - 1);
  localparam logic [c_cw-1:0] c_stop_last = c_cw'(c_stop_clks - 1);
  localparam logic [c_bw-1:0] c_word_last = c_bw'(DATABITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_of(input logic [DATABITS-1:0] d);
    if (PARITY == "O")      return ~^d;
    else if (PARITY == "E") return ^d;
    else if (PARITY == "M") return 1'b1;
    else                    return 1'b0;
  endfunction

  // ---------------- transmitter ----------------
  state_t              r_tx_state;
  logic [c_cw-1:0]     r_tx_cnt;
  logic [c_bw-1:0]     r_tx_bit;
  logic [DATABITS-1:0] r_tx_shift;
  logic                r_tx_par;
  logic                r_txd;
  logic                r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_tx_state)
        ST_IDLE: begin
          if (bus.tx_en) begin
            r_tx_shift <= bus.tx_data;
            r_tx_par   <= parity_of(bus.tx_data);
            r_tx_cnt   <= c_bit_last;
            r_txd      <= 1'b0;
            r_busy     <= 1'b1;
            r_tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt   <= c_bit_last;
            r_tx_bit   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_state <= ST_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (r_tx_cnt == '0) begin
            if (r_tx_bit == c_word_last) begin
              if (c_has_par) begin
                r_tx_cnt   <= c_bit_last;
                r_txd      <= r_tx_par;
                r_tx_state <= ST_PARITY;
              end else begin
                r_tx_cnt   <= c_stop_last;
                r_txd      <= 1'b1;
                r_tx_state <= ST_STOP;
              end
            end else begin
              r_tx_cnt   <= c_bit_last;
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        ST_PARITY: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt   <= c_stop_last;
            r_txd      <= 1'b1;
            r_tx_state <= ST_STOP;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          // busy falls one cycle after the stop period; that cycle can accept the next word
          if (r_tx_cnt == '0) begin
            r_busy     <= 1'b0;
            r_tx_state <= ST_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        default: begin
          r_txd      <= 1'b1;
          r_busy     <= 1'b0;
          r_tx_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  // Two-flop synchronizer followed by a two-deep history; r_hist1 is the mid-bit tap
  // so the vote can use one sample on each side without shifting O_valid timing.
  logic r_sync1, r_sync2, r_hist1, r_hist2;
  logic w_fall;
  logic w_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist1 <= 1'b1;
      r_hist2 <= 1'b1;
    end else begin
      r_sync1 <= bus.rxd;
      r_sync2 <= r_sync1;
      r_hist1 <= r_sync2;
      r_hist2 <= r_hist1;
    end
  end

  assign w_fall = r_hist2 & ~r_hist1;

`ifdef UART_RX_MAJORITY_EN
  assign w_bit = (r_sync2 & r_hist1) | (r_sync2 & r_hist2) | (r_hist1 & r_hist2);
`else
  assign w_bit = r_hist1;
`endif

  state_t              r_rx_state;
  logic [c_cw-1:0]     r_rx_cnt;
  logic [c_bw-1:0]     r_rx_bit;
  logic [DATABITS-1:0] r_rx_shift;
  logic                r_rx_par_err;
  logic [DATABITS-1:0] r_rx_data;
  logic                r_valid;
  logic                r_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state   <= ST_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_par_err <= 1'b0;
      r_rx_data    <= '0;
      r_valid      <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      case (r_rx_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_rx_cnt     <= c_half_last;
            r_rx_par_err <= 1'b0;
            r_rx_state   <= ST_START;
          end
        end
        ST_START: begin
          if (r_rx_cnt == '0) begin
            if (w_bit) begin
              r_rx_state <= ST_IDLE;
            end else begin
              r_rx_cnt   <= c_bit_last;
              r_rx_bit   <= '0;
              r_rx_state <= ST_DATA;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (r_rx_cnt == '0) begin
            r_rx_shift <= {w_bit, r_rx_shift[DATABITS-1:1]};
            r_rx_cnt   <= c_bit_last;
            if (r_rx_bit == c_word_last) begin
              r_rx_state <= c_has_par ? ST_PARITY : ST_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        ST_PARITY: begin
          if (r_rx_cnt == '0) begin
            r_rx_par_err <= w_bit ^ parity_of(r_rx_shift);
            r_rx_cnt     <= c_bit_last;
            r_rx_state   <= ST_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          // only the first stop bit is examined; the word is delivered even when flagged
          if (r_rx_cnt == '0) begin
            r_rx_data  <= r_rx_shift;
            r_valid    <= 1'b1;
            r_error    <= r_rx_par_err | (c_chk_stop & ~w_bit);
            r_rx_state <= ST_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        default: r_rx_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.txd      = r_txd;
  assign bus.tx_busy  = r_busy;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_valid;
  assign bus.rx_error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_uart_top_core.sv
// tb_uart_top_core : directed loopback/external-drive bench with an RX scoreboard queue.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_uart_top_core;
  localparam int N  = 7;
  localparam int BP = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] tx_en = '0;
  logic [N-1:0] loop  = '1;
  logic [N-1:0] busy, valid, err, txd;
  logic         ext_rxd = 1'b1;
  logic [7:0]   tx_data [N];
  logic [7:0]   rx_data [N];

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_o, mon_e;

  // instance map: 0 8N1, 1 8E1, 2 8O1, 3 8M1, 4 8S1, 5 8N1 stop unchecked, 6 8N2
  generate
    for (genvar i = 0; i < N; i++) begin : g_dut
      localparam string G_PAR  = (i == 1) ? "E" : (i == 2) ? "O" : (i == 3) ? "M" : (i == 4) ? "S" : "N";
      localparam real   G_STOP = (i == 6) ? 2.0 : 1.0;
      localparam string G_CHK  = (i == 5) ? "DISABLE" : "ENABLE";
      uart_top_core_if #(.DATABITS(8)) bus ();
      assign bus.tx_data = tx_data[i];
      assign bus.tx_en   = tx_en[i];
      assign bus.rxd     = loop[i] ? bus.txd : ext_rxd;
      assign busy[i]     = bus.tx_busy;
      assign valid[i]    = bus.rx_valid;
      assign err[i]      = bus.rx_error;
      assign txd[i]      = bus.txd;
      assign rx_data[i]  = bus.rx_data;
      uart_top_core #(
        .FREQUENCY (960000),
        .BAUDRATE  (9600),
        .DATABITS  (8),
        .PARITY    (G_PAR),
        .STOPBITS  (G_STOP),
        .CHECKSTOP (G_CHK)
      ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit has_par(input int i);
    return (i >= 1 && i <= 4);
  endfunction

  function automatic logic par_bit(input int i, input logic [7:0] d);
    case (i)
      1: return ^d;
      2: return ~^d;
      3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int stop_halves(input int i);
    return (i == 6) ? 4 : 2;
  endfunction

  function automatic logic frame_bit(input int i, input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && has_par(i)) return par_bit(i, d);
    return 1'b1;
  endfunction

  // scoreboard: every rx_valid pops one expected {instance, error, data}
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (valid[i] === 1'b1) begin
        mon_o = {3'(i), err[i], rx_data[i]};
        mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
        chk($sformatf("rx_word_i%0d", i), 32'(mon_o), 32'(mon_e));
      end
    end
  end

  // call at a negedge; returns just after the capturing posedge
  task automatic send(input int i, input logic [7:0] d, input bit push);
    tx_data[i] = d;
    tx_en[i]   = 1'b1;
    if (push) exp_q.push_back({3'(i), 1'b0, d});
    @(posedge clk);
    #1 tx_en[i] = 1'b0;
  endtask

  task automatic tx_check(input int i, input logic [7:0] d);
    int  bc = 0;
    bit  done = 0;
    int  nb = 9 + int'(has_par(i)) + stop_halves(i) / 2;
    int  blen = BP * (9 + int'(has_par(i))) + (BP * stop_halves(i)) / 2;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if ((c % BP) == BP / 2 && (c / BP) < nb)
        chk($sformatf("txd_i%0d_bit%0d", i, c / BP), 32'(txd[i]), 32'(frame_bit(i, d, c / BP)));
      if (busy[i]) bc++;
      else done = 1;
    end
    chk($sformatf("busy_len_i%0d", i), bc, blen);
  endtask

  task automatic drive_rx(input logic [7:0] d, input bit with_par, input logic pbit, input logic sbit);
    ext_rxd = 1'b0;
    repeat (BP) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      ext_rxd = d[b];
      repeat (BP) @(negedge clk);
    end
    if (with_par) begin
      ext_rxd = pbit;
      repeat (BP) @(negedge clk);
    end
    ext_rxd = sbit;
    repeat (BP) @(negedge clk);
    ext_rxd = 1'b1;
    repeat (BP) @(negedge clk);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    for (int i = 0; i < N; i++) tx_data[i] = 8'h00;

    #30;
    chk("reset_txd",   32'(txd[0]),   32'h1);
    chk("reset_busy",  32'(busy[0]),  32'h0);
    chk("reset_data",  32'(rx_data[0]), 32'h0);
    chk("reset_valid", 32'(valid[0]), 32'h0);
    chk("reset_error", 32'(err[0]),   32'h0);
    #25 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 loopback
    send(0, 8'h5A, 1'b1);
    tx_check(0, 8'h5A);
    repeat (20) @(negedge clk);

    // parity modes in loopback
    for (int i = 1; i <= 4; i++) begin
      send(i, 8'h5A, 1'b1);
      tx_check(i, 8'h5A);
      repeat (20) @(negedge clk);
    end

    // even parity, wrong parity bit on the wire
    loop[1] = 1'b0;
    exp_q.push_back({3'd1, 1'b1, 8'h5A});
    drive_rx(8'h5A, 1'b1, 1'b1, 1'b1);
    loop[1] = 1'b1;

    // low stop bit, checked then unchecked
    loop[0] = 1'b0;
    exp_q.push_back({3'd0, 1'b1, 8'hC3});
    drive_rx(8'hC3, 1'b0, 1'b0, 1'b0);
    loop[0] = 1'b1;
    loop[5] = 1'b0;
    exp_q.push_back({3'd5, 1'b0, 8'h3C});
    drive_rx(8'h3C, 1'b0, 1'b0, 1'b0);
    loop[5] = 1'b1;

    // false start: 30-clock glitch
    loop[0] = 1'b0;
    ext_rxd = 1'b0;
    repeat (30) @(negedge clk);
    ext_rxd = 1'b1;
    repeat (300) @(negedge clk);
    loop[0] = 1'b1;
    chk("glitch_no_word", exp_q.size(), 0);

    // requests while busy are dropped
    send(0, 8'h81, 1'b1);
    repeat (300) @(negedge clk);
    send(0, 8'hFF, 1'b0);
    repeat (300) @(negedge clk);
    send(0, 8'hFF, 1'b0);
    for (int c = 0; c < 2000 && busy[0]; c++) @(negedge clk);
    chk("busy_drop", 32'(busy[0]), 32'h0);
    repeat (500) @(negedge clk);
    chk("no_queued_frame", 32'(busy[0]), 32'h0);
    chk("idle_txd", 32'(txd[0]), 32'h1);

    // two stop bits, back-to-back
    send(6, 8'hA5, 1'b1);
    tx_check(6, 8'hA5);
    send(6, 8'h3C, 1'b1);
    tx_check(6, 8'h3C);
    repeat (20) @(negedge clk);

    // asynchronous reset in the middle of a frame (while a data 0 is on the wire)
    send(6, 8'h55, 1'b0);
    repeat (250) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_txd",  32'(txd[6]),     32'h1);
    chk("midreset_busy", 32'(busy[6]),    32'h0);
    chk("midreset_data", 32'(rx_data[6]), 32'h0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send(6, 8'h99, 1'b1);
    tx_check(6, 8'h99);
    repeat (50) @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
